// File: rtl/pe_dual_mode.sv
// Dual-mode (WS/OS) systolic PE with double-buffered weight and valid tags; all outputs 1-cycle registered, no backpressure.
// Build with PE_SAT_EN defined to saturate sums/accumulates and expose the sticky sat_flag output.
module pe_dual_mode #(
  parameter int DATA_IN_BW     = 8,
  parameter int WEIGHT_BW      = 8,
  parameter int PARTIAL_SUM_BW = 19
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             mode,
  input  logic                             start,
  input  logic                             stop,
  input  logic signed [DATA_IN_BW-1:0]     DIN,
  input  logic                             din_valid,
  input  logic signed [WEIGHT_BW-1:0]      W_IN,
  input  logic                             w_load,
  input  logic                             w_swap,
  input  logic signed [PARTIAL_SUM_BW-1:0] PSUM_IN,
  input  logic                             psum_in_valid,
  output logic signed [DATA_IN_BW-1:0]     DF_COL,
  output logic                             df_valid,
  output logic signed [WEIGHT_BW-1:0]      W_OUT,
  output logic signed [PARTIAL_SUM_BW-1:0] PSUM_OUT,
  output logic                             psum_out_valid,
  output logic                             busy
`ifdef PE_SAT_EN
  ,
  output logic                             sat_flag
`endif
);

  localparam int PB  = DATA_IN_BW + WEIGHT_BW;
  localparam int PSW = PARTIAL_SUM_BW;
  localparam logic signed [PSW-1:0] MAXV = {1'b0, {(PSW-1){1'b1}}};
  localparam logic signed [PSW-1:0] MINV = {1'b1, {(PSW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic signed [WEIGHT_BW-1:0] shadow_q, shadow_d, active_q, active_d;
  logic signed [PSW-1:0]  acc_q, acc_d, psum_q, psum_d;
  logic                   pvld_q, pvld_d;
  logic signed [DATA_IN_BW-1:0] dfcol_q;
  logic                   dfvld_q;
  logic signed [WEIGHT_BW-1:0]  wout_q;
`ifdef PE_SAT_EN
  logic                   sat_q, sat_d;
`endif

  logic signed [WEIGHT_BW-1:0] w_op;
  logic signed [PB-1:0]   prod;
  logic signed [PSW-1:0]  p_ext, ws_sum, os_sum;

  function automatic logic signed [PSW-1:0] add_fn(input logic signed [PSW-1:0] a,
                                                   input logic signed [PSW-1:0] b);
`ifdef PE_SAT_EN
    logic signed [PSW:0] w;
    w = (PSW+1)'(a) + (PSW+1)'(b);
    if (w[PSW] != w[PSW-1]) add_fn = w[PSW] ? MINV : MAXV;
    else                    add_fn = w[PSW-1:0];
`else
    add_fn = a + b;
`endif
  endfunction

`ifdef PE_SAT_EN
  function automatic logic ovf_fn(input logic signed [PSW-1:0] a,
                                  input logic signed [PSW-1:0] b);
    logic signed [PSW:0] w;
    w = (PSW+1)'(a) + (PSW+1)'(b);
    ovf_fn = (w[PSW] != w[PSW-1]);
  endfunction
`endif

  // OS streams W_IN as the operand; WS uses the active buffered weight.
  assign w_op   = mode_q ? W_IN : active_q;
  assign prod   = $signed({{WEIGHT_BW{DIN[DATA_IN_BW-1]}}, DIN}) *
                  $signed({{DATA_IN_BW{w_op[WEIGHT_BW-1]}}, w_op});
  assign p_ext  = PSW'(prod);
  assign ws_sum = add_fn(PSUM_IN, p_ext);
  assign os_sum = add_fn(acc_q, p_ext);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    active_d = active_q;
    acc_d    = acc_q;
    psum_d   = psum_q;
    pvld_d   = 1'b0;
`ifdef PE_SAT_EN
    sat_d    = sat_q;
`endif
    if (w_load) shadow_d = W_IN;
    if (w_swap) active_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
`ifdef PE_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (stop) state_d = mode_q ? DRAIN : IDLE;
        if (!mode_q) begin
          pvld_d = din_valid & psum_in_valid;
          if (din_valid && psum_in_valid) begin
            psum_d = ws_sum;
`ifdef PE_SAT_EN
            if (ovf_fn(PSUM_IN, p_ext)) sat_d = 1'b1;
`endif
          end
        end else begin
          psum_d = PSUM_IN;
          pvld_d = psum_in_valid;
          if (din_valid) begin
            acc_d = os_sum;
`ifdef PE_SAT_EN
            if (ovf_fn(acc_q, p_ext)) sat_d = 1'b1;
`endif
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        psum_d  = acc_q;
        pvld_d  = 1'b1;
        acc_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      acc_q    <= '0;
      psum_q   <= '0;
      pvld_q   <= 1'b0;
      dfcol_q  <= '0;
      dfvld_q  <= 1'b0;
      wout_q   <= '0;
`ifdef PE_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      psum_q   <= psum_d;
      pvld_q   <= pvld_d;
      dfcol_q  <= DIN;
      dfvld_q  <= din_valid;
      wout_q   <= W_IN;
`ifdef PE_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign DF_COL         = dfcol_q;
  assign df_valid       = dfvld_q;
  assign W_OUT          = wout_q;
  assign PSUM_OUT       = psum_q;
  assign psum_out_valid = pvld_q;
  assign busy           = (state_q != IDLE);
`ifdef PE_SAT_EN
  assign sat_flag       = sat_q;
`endif

endmodule

// File: tb/tb_pe_dual_mode.sv
// Directed-vector bench for pe_dual_mode; a second 16-bit-psum instance covers the overflow boundary.
module tb_pe_dual_mode;

  logic clk = 1'b0;
  logic rstn;
  logic mode, start, stop, din_valid, w_load, w_swap, psum_in_valid;
  logic signed [7:0]  din, w_in;
  logic signed [18:0] psum_in;
  logic signed [15:0] psum_in16;
  logic signed [7:0]  df_col, w_out, df_col16, w_out16;
  logic               df_valid, psum_out_valid, busy;
  logic               df_valid16, psum_out_valid16, busy16;
  logic signed [18:0] psum_out;
  logic signed [15:0] psum_out16;
`ifdef PE_SAT_EN
  logic sat_flag, sat_flag16;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pe_dual_mode #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19)) u_dut (
    .clk(clk), .rstn(rstn), .mode(mode), .start(start), .stop(stop),
    .DIN(din), .din_valid(din_valid), .W_IN(w_in), .w_load(w_load), .w_swap(w_swap),
    .PSUM_IN(psum_in), .psum_in_valid(psum_in_valid),
    .DF_COL(df_col), .df_valid(df_valid), .W_OUT(w_out),
    .PSUM_OUT(psum_out), .psum_out_valid(psum_out_valid), .busy(busy)
`ifdef PE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  pe_dual_mode #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .mode(mode), .start(start), .stop(stop),
    .DIN(din), .din_valid(din_valid), .W_IN(w_in), .w_load(w_load), .w_swap(w_swap),
    .PSUM_IN(psum_in16), .psum_in_valid(psum_in_valid),
    .DF_COL(df_col16), .df_valid(df_valid16), .W_OUT(w_out16),
    .PSUM_OUT(psum_out16), .psum_out_valid(psum_out_valid16), .busy(busy16)
`ifdef PE_SAT_EN
    , .sat_flag(sat_flag16)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    mode = 0; start = 0; stop = 0; din = 0; din_valid = 0; w_in = 0;
    w_load = 0; w_swap = 0; psum_in = 0; psum_in16 = 0; psum_in_valid = 0;
  endtask

  task automatic ws_vec(input int d, input int p, input string tag, input int exp);
    din = 8'(d); din_valid = 1; psum_in = 19'(p); psum_in_valid = 1;
    tick();
    chk(tag, psum_out, exp);
  endtask

  initial begin
    clr_in();
    rstn = 0;
    din = 8'sd7; din_valid = 1; w_in = 8'sd9; psum_in = 19'sd44; psum_in_valid = 1;
    tick(); tick();
    chk("rst_dfcol", df_col, 0);
    chk("rst_dfvld", df_valid, 0);
    chk("rst_wout", w_out, 0);
    chk("rst_psum", psum_out, 0);
    chk("rst_pvld", psum_out_valid, 0);
    chk("rst_busy", busy, 0);
    clr_in();
    rstn = 1;

    // forwarding in IDLE, stop ignored in IDLE
    din = -8'sd3; din_valid = 1; w_in = 8'sd9; stop = 1; psum_in_valid = 1;
    tick();
    chk("fwd_dfcol", df_col, -3);
    chk("fwd_dfvld", df_valid, 1);
    chk("fwd_wout", w_out, 9);
    chk("idle_pvld", psum_out_valid, 0);
    chk("idle_stop_busy", busy, 0);
    clr_in();

    // WS pass
    w_in = 8'sd3; w_load = 1; tick();
    w_load = 0; w_swap = 1; tick();
    w_swap = 0; mode = 0; start = 1; tick();
    start = 0;
    chk("ws_busy", busy, 1);
    ws_vec(5, 10, "ws_pass", 25);
    chk("ws_pvld", psum_out_valid, 1);
    psum_in_valid = 0; psum_in = 19'sd99; tick();
    chk("ws_hold", psum_out, 25);
    chk("ws_vld_drop", psum_out_valid, 0);

    // double buffer
    w_in = 8'sd7; w_load = 1;
    ws_vec(5, 0, "db_load", 15);
    w_load = 0; w_swap = 1;
    ws_vec(2, 0, "db_swapcyc", 6);
    w_swap = 0;
    ws_vec(2, 0, "db_after", 14);
    w_in = 8'sd2; w_load = 1; w_swap = 1;
    ws_vec(1, 0, "db_both", 7);
    w_load = 0; w_swap = 0;
    ws_vec(1, 0, "db_act7", 7);
    w_swap = 1;
    ws_vec(1, 0, "db_swap2", 7);
    w_swap = 0;
    ws_vec(1, 0, "db_shadow2", 2);
    ws_vec(-4, -100, "ws_neg", -108);
    clr_in(); stop = 1; tick(); stop = 0;
    chk("ws_stop_idle", busy, 0);

    // OS accumulate and chain
    mode = 1; start = 1; tick(); start = 0; mode = 0;
    din = 8'sd2; w_in = 8'sd3; din_valid = 1; psum_in = 19'h123; psum_in_valid = 1;
    tick();
    chk("os_chain", psum_out, 'h123);
    chk("os_chain_vld", psum_out_valid, 1);
    din = -8'sd4; w_in = 8'sd5; psum_in = 19'h55; psum_in_valid = 0;
    tick();
    chk("os_chain_novld", psum_out_valid, 0);
    chk("os_chain_dat", psum_out, 'h55);
    din = 8'sd100; w_in = 8'sd100; din_valid = 0; tick();
    din = 8'sd6; w_in = 8'sd1; din_valid = 1; tick();
    clr_in(); stop = 1; tick(); stop = 0;
    chk("os_drain_busy", busy, 1);
    start = 1; tick(); start = 0;
    chk("os_drain_val", psum_out, -8);
    chk("os_drain_vld", psum_out_valid, 1);
    chk("os_drain_end", busy, 0);
    tick();
    chk("os_post_vld", psum_out_valid, 0);
    chk("os_post_hold", psum_out, -8);
    mode = 1; start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("start_wins", busy, 1);
    stop = 1; tick(); stop = 0; tick();
    chk("acc_cleared", psum_out, 0);
    chk("acc_clr_vld", psum_out_valid, 1);

    // reset mid-RUN
    mode = 1; start = 1; tick(); start = 0;
    din = 8'sd3; w_in = 8'sd3; din_valid = 1; psum_in = 19'sd77; psum_in_valid = 1; tick();
    din = 8'sd1; w_in = 8'sd1; tick();
    rstn = 0; #2;
    chk("mrst_busy", busy, 0);
    chk("mrst_psum", psum_out, 0);
    chk("mrst_pvld", psum_out_valid, 0);
    chk("mrst_dfcol", df_col, 0);
    chk("mrst_wout", w_out, 0);
    clr_in();
    tick(); rstn = 1;
    mode = 1; start = 1; tick(); start = 0;
    stop = 1; tick(); stop = 0; tick();
    chk("mrst_drain", psum_out, 0);
    chk("mrst_drain_vld", psum_out_valid, 1);

    // overflow: weight 1 in WS
    w_in = 8'sd1; w_load = 1; tick();
    w_load = 0; w_swap = 1; tick();
    w_swap = 0; mode = 0; start = 1; tick(); start = 0;
`ifdef PE_SAT_EN
    chk("sat_clr", sat_flag16, 0);
`endif
    din = 8'sd1; din_valid = 1; psum_in = 19'sd32767; psum_in16 = 16'sd32767; psum_in_valid = 1;
    tick();
    chk("ovf19_pos", psum_out, 32768);
`ifdef PE_SAT_EN
    chk("ovf16_pos_sat", psum_out16, 32767);
    chk("sat_set", sat_flag16, 1);
    chk("sat19_clear", sat_flag, 0);
`else
    chk("ovf16_pos_wrap", psum_out16, -32768);
`endif
    din = 8'sd1; psum_in16 = 16'sd5; tick();
    chk("ovf16_norm", psum_out16, 6);
`ifdef PE_SAT_EN
    chk("sat_sticky", sat_flag16, 1);
`endif
    din = -8'sd1; psum_in16 = -16'sd32768; tick();
`ifdef PE_SAT_EN
    chk("ovf16_neg_sat", psum_out16, -32768);
`else
    chk("ovf16_neg_wrap", psum_out16, 32767);
`endif
    clr_in(); stop = 1; tick(); stop = 0;
    start = 1; tick(); start = 0;
`ifdef PE_SAT_EN
    chk("sat_start_clr", sat_flag16, 0);
`endif
    chk("ovf_restart_busy", busy16, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_dual_mode.md
Name: pe_dual_mode

Overview:
- Next-generation systolic processing element for the parametrised MXU.
- Supports two dataflows, selected by a mode bit:
  - Weight-stationary (WS): psum flows right through the array.
  - Output-stationary (OS): local accumulator, drained onto the psum chain.
- Adds a double-buffered weight register so weights can reload with no stall.
- Adds valid tagging on every data path. Tiled as an R x C grid by the array wrapper.

Parameters:
- DATA_IN_BW, 8, signed activation width.
- WEIGHT_BW, 8, signed weight width.
- PARTIAL_SUM_BW, 19, signed psum/accumulator width; must be >= DATA_IN_BW+WEIGHT_BW.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- mode  in  1  0=WS, 1=OS; sampled only in IDLE.
- start  in  1  pulse: leave IDLE, enter RUN with the captured mode.
- stop  in  1  pulse: end RUN (WS: go to IDLE; OS: go to DRAIN).
- DIN  in  DATA_IN_BW  activation from left/top neighbour.
- din_valid  in  1  DIN qualifier.
- W_IN  in  WEIGHT_BW  weight (WS: shadow-load source; OS: streaming operand).
- w_load  in  1  WS: capture W_IN into shadow register.
- w_swap  in  1  WS: copy shadow into active weight.
- PSUM_IN  in  PARTIAL_SUM_BW  psum from neighbour.
- psum_in_valid  in  1  PSUM_IN qualifier.
- DF_COL  out  DATA_IN_BW  registered DIN forward.
- df_valid  out  1  registered din_valid.
- W_OUT  out  WEIGHT_BW  registered W_IN forward.
- PSUM_OUT  out  PARTIAL_SUM_BW  registered psum / drained accumulator.
- psum_out_valid  out  1  PSUM_OUT qualifier.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset: all outputs 0; shadow weight, active weight and accumulator 0; state IDLE.
- Forwarding: DF_COL, df_valid and W_OUT are 1-cycle registered copies in every state, including IDLE.
- Product p = DIN * weight_operand, signed, DATA_IN_BW+WEIGHT_BW bits, then sign-extended to PARTIAL_SUM_BW.
  - WS operand: active weight.
  - OS operand: W_IN.
- FSM:
  - IDLE -> RUN on start; mode is latched into mode_q at this transition.
  - RUN -> IDLE on stop when mode_q=0.
  - RUN -> DRAIN on stop when mode_q=1.
  - DRAIN -> IDLE after exactly 1 cycle.
  - start while busy is ignored. stop in IDLE or DRAIN is ignored. start and stop together in IDLE: start wins.
- WS in RUN:
  - PSUM_OUT <= PSUM_IN + p.
  - psum_out_valid <= din_valid & psum_in_valid.
  - If not both valid: PSUM_OUT holds its value, valid drops.
- OS in RUN:
  - acc <= acc + p when din_valid is high; otherwise acc holds.
  - PSUM_OUT <= PSUM_IN; psum_out_valid <= psum_in_valid (shift-out chain for neighbours' drained results).
- DRAIN:
  - PSUM_OUT <= acc; psum_out_valid <= 1; acc <= 0.
  - PSUM_IN present in the same cycle is dropped; the array controller guarantees drain skew so this cannot collide.
- IDLE: psum_out_valid <= 0; PSUM_OUT holds its value.
- Weight buffer (active in every state):
  - w_load: shadow <= W_IN.
  - w_swap: active <= shadow.
  - Both in the same cycle: active gets the OLD shadow, shadow gets the new W_IN.
  - A swap takes effect on the first product of the next cycle.
- Arithmetic: two's complement. Overflow behaviour is set by the Optional Feature; default is wrap modulo 2^PARTIAL_SUM_BW.
- Reset mid-RUN or mid-DRAIN: immediate return to IDLE; accumulator and weights cleared; no drain output.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined:
  - WS sum and OS accumulate both saturate to [-2^(PARTIAL_SUM_BW-1), 2^(PARTIAL_SUM_BW-1)-1].
  - Sticky output sat_flag (1 bit) is added; it sets on any clamp and clears on reset or start.
- Undefined: results wrap modulo 2^PARTIAL_SUM_BW, and no sat_flag port exists.

Test Plan:
- WS pass: shadow load 3, swap, start mode=0; DIN=5, PSUM_IN=10, both valid -> next cycle PSUM_OUT=25, psum_out_valid=1.
- Double buffer: during RUN, load 7 while active=3, swap at cycle N -> product uses 3 through cycle N, 7 from N+1. Load+swap together with shadow=7, W_IN=2 -> active=7, shadow=2.
- OS accumulate: start mode=1; (DIN,W_IN) = (2,3), (-4,5), (6,1), all valid, then stop -> DRAIN PSUM_OUT=-8, valid for 1 cycle; busy low the next cycle; acc=0.
- OS chain: in RUN, PSUM_IN=0x123 with valid -> PSUM_OUT=0x123 one cycle later; din_valid=0 cycles leave acc unchanged.
- Reset mid-RUN after two OS accumulates -> all outputs 0, IDLE, and a following start/stop yields a drain of 0.
- Overflow: PARTIAL_SUM_BW=16, WS PSUM_IN=32767, DIN=1, weight=1 -> with PE_SAT_EN: 32767 and sat_flag=1; without it: -32768.
